vx_mem_req_tracker: RTL and testbench

//  Sits between a core's icache/dcache master port and the cache. Tracks outstanding reads in a slot table.

---
 rtl/vx_mem_req_tracker.sv | 167 ++++++++++++++++
 tb/tb_vx_mem_req_tracker.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_req_tracker.sv
// vx_mem_req_tracker: outstanding-read slot table between a core memory
// port and the cache. Swaps core tags for slot indices and restores them.
// Ports: clk, reset (async, active high); core_req_* in / core_req_ready out;
// mem_req_* out / mem_req_ready in; mem_rsp_* in / mem_rsp_ready out;
// core_rsp_* out / core_rsp_ready in; pending, busy, err_unmatched status;
// perf_reads/perf_writes/perf_latency counters.
// Optional feature macro: MEM_TRACKER_PERF_EN (perf counters built when set).
module vx_mem_req_tracker #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 8,
    parameter int CTR_BITS    = 44,
    localparam int SLOT_W     = $clog2(MAX_PENDING)
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    core_req_valid,
    input  logic                    core_req_rw,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_req_ready,

    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [SLOT_W-1:0]       mem_req_tag,
    input  logic                    mem_req_ready,

    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [SLOT_W-1:0]       mem_rsp_tag,
    output logic                    mem_rsp_ready,

    output logic                    core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    input  logic                    core_rsp_ready,

    output logic [SLOT_W:0]         pending,
    output logic                    busy,
    output logic                    err_unmatched,

    output logic [CTR_BITS-1:0]     perf_reads,
    output logic [CTR_BITS-1:0]     perf_writes,
    output logic [CTR_BITS-1:0]     perf_latency
);

    localparam logic [SLOT_W:0] PEND_ONE = 1;

    logic [MAX_PENDING-1:0] free_mask;
    logic [TAG_WIDTH-1:0]   tag_table [MAX_PENDING];
    logic [SLOT_W:0]        pending_q;
    logic                   err_q;

    logic                   has_free;
    logic                   req_ok;
    logic                   read_fire;
    logic                   rsp_fire;
    logic                   rsp_hit;
    logic                   rsp_miss;
    logic [SLOT_W-1:0]      alloc_slot;

    assign has_free = |free_mask;
    // Writes never occupy a slot, so only reads are gated by a full table.
    assign req_ok   = core_req_rw || has_free;

    assign mem_req_valid  = core_req_valid && req_ok;
    assign core_req_ready = mem_req_ready && req_ok;
    assign mem_req_rw     = core_req_rw;
    assign mem_req_addr   = core_req_addr;
    assign mem_req_data   = core_req_data;
    assign mem_req_byteen = core_req_byteen;
    assign mem_req_tag    = core_req_rw ? '0 : alloc_slot;

    // Lowest free slot; scanning downward lets the lowest index win.
    always_comb begin
        alloc_slot = '0;
        for (int i = MAX_PENDING - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                alloc_slot = SLOT_W'(i);
            end
        end
    end

    assign read_fire = core_req_valid && core_req_ready && !core_req_rw;
    assign rsp_fire  = mem_rsp_valid && core_rsp_ready;
    assign rsp_hit   = rsp_fire && !free_mask[mem_rsp_tag];
    assign rsp_miss  = rsp_fire && free_mask[mem_rsp_tag];

    assign mem_rsp_ready  = core_rsp_ready;
    assign core_rsp_valid = mem_rsp_valid;
    assign core_rsp_data  = mem_rsp_data;
    assign core_rsp_tag   = tag_table[mem_rsp_tag];

    // The allocated slot is free and a hit slot is busy, so the two
    // updates below never touch the same bit in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_mask <= '1;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (read_fire) begin
                free_mask[alloc_slot] <= 1'b0;
            end
            if (rsp_hit) begin
                free_mask[mem_rsp_tag] <= 1'b1;
            end
            if (read_fire && !rsp_hit) begin
                pending_q <= pending_q + PEND_ONE;
            end else if (!read_fire && rsp_hit) begin
                pending_q <= pending_q - PEND_ONE;
            end
            if (rsp_miss) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage is pure data; stale entries are harmless and left as-is.
    always_ff @(posedge clk) begin
        if (read_fire) begin
            tag_table[alloc_slot] <= core_req_tag;
        end
    end

    assign pending       = pending_q;
    assign busy          = (pending_q != '0);
    assign err_unmatched = err_q;

`ifdef MEM_TRACKER_PERF_EN
    logic                write_fire;
    logic [CTR_BITS-1:0] reads_q;
    logic [CTR_BITS-1:0] writes_q;
    logic [CTR_BITS-1:0] latency_q;

    assign write_fire = core_req_valid && core_req_ready && core_req_rw;

    // Summing occupancy every cycle yields total read latency in cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reads_q   <= '0;
            writes_q  <= '0;
            latency_q <= '0;
        end else begin
            reads_q   <= reads_q + CTR_BITS'(read_fire);
            writes_q  <= writes_q + CTR_BITS'(write_fire);
            latency_q <= latency_q + CTR_BITS'(pending_q);
        end
    end

    assign perf_reads   = reads_q;
    assign perf_writes  = writes_q;
    assign perf_latency = latency_q;
`else
    assign perf_reads   = '0;
    assign perf_writes  = '0;
    assign perf_latency = '0;
`endif

endmodule

// File: tb/tb_vx_mem_req_tracker.sv
// tb_vx_mem_req_tracker: scoreboard bench for vx_mem_req_tracker with a
// slot-set reference model, directed scenarios and a randomized phase.
module tb_vx_mem_req_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req_valid = 1'b0;
    logic        core_req_rw = 1'b0;
    logic [31:0] core_req_addr = '0;
    logic [63:0] core_req_data = '0;
    logic [7:0]  core_req_byteen = '0;
    logic [7:0]  core_req_tag = '0;
    logic        core_req_ready;
    logic        mem_req_valid;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic [7:0]  mem_req_byteen;
    logic [2:0]  mem_req_tag;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_data = '0;
    logic [2:0]  mem_rsp_tag = '0;
    logic        mem_rsp_ready;
    logic        core_rsp_valid;
    logic [63:0] core_rsp_data;
    logic [7:0]  core_rsp_tag;
    logic        core_rsp_ready = 1'b0;
    logic [3:0]  pending;
    logic        busy;
    logic        err_unmatched;
    logic [43:0] perf_reads;
    logic [43:0] perf_writes;
    logic [43:0] perf_latency;

    vx_mem_req_tracker dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data),
        .core_req_byteen(core_req_byteen), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
        .pending(pending), .busy(busy), .err_unmatched(err_unmatched),
        .perf_reads(perf_reads), .perf_writes(perf_writes),
        .perf_latency(perf_latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [2:0]  tag;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
        bit          known;
    } rsp_t;

    typedef struct {
        bit     ready;
        bit     mval;
        bit     srdy;
        bit     cval;
        int     pend;
        bit     err;
        longint pr;
        longint pw;
        longint pl;
    } stat_t;

    req_t  req_q[$];
    rsp_t  rsp_q[$];
    stat_t stat_q[$];

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: a set of busy slots with the tag each one holds.
    bit         m_busy [8];
    logic [7:0] m_tag  [8];
    bit         m_wr   [8];
    bit         m_err;
    longint     m_pr, m_pw, m_pl;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < 8; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic stat_t m_stat(bit rdy, bit mv, bit sr, bit cv);
        stat_t s;
        s.ready = rdy; s.mval = mv; s.srdy = sr; s.cval = cv;
        s.pend = m_count();
        s.err = m_err;
`ifdef MEM_TRACKER_PERF_EN
        s.pr = m_pr; s.pw = m_pw; s.pl = m_pl;
`else
        s.pr = 0; s.pw = 0; s.pl = 0;
`endif
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        core_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
        m_err = 1'b0; m_pr = 0; m_pw = 0; m_pl = 0;
        stat_q.push_back(m_stat(mem_req_ready, 1'b0, core_rsp_ready, 1'b0));
    endtask

    task automatic drive_cycle(input bit rv, input bit rw,
                               input logic [7:0] tg, input bit mrdy,
                               input bit sv, input logic [2:0] st,
                               input bit crdy);
        int   lo;
        bit   ok, rdy, rd_fire, wr_fire, pre_busy;
        req_t r;
        rsp_t p;
        @(negedge clk);
        reset = 1'b0;
        core_req_valid = rv;
        core_req_rw = rw;
        core_req_addr = $urandom;
        core_req_data = {$urandom, $urandom};
        core_req_byteen = 8'($urandom);
        core_req_tag = tg;
        mem_req_ready = mrdy;
        mem_rsp_valid = sv;
        mem_rsp_data = {$urandom, $urandom};
        mem_rsp_tag = st;
        core_rsp_ready = crdy;

        lo  = m_lowest();
        ok  = rw || (lo >= 0);
        rdy = mrdy && ok;
        stat_q.push_back(m_stat(rdy, rv && ok, crdy, sv));
        if (rv && rdy) begin
            r.rw = rw; r.addr = core_req_addr; r.data = core_req_data;
            r.be = core_req_byteen;
            r.tag = rw ? 3'd0 : 3'(lo);
            req_q.push_back(r);
        end
        pre_busy = m_busy[st];
        if (sv && crdy) begin
            p.data = mem_rsp_data; p.tag = m_tag[st]; p.known = m_wr[st];
            rsp_q.push_back(p);
        end

        rd_fire = rv && rdy && !rw;
        wr_fire = rv && rdy && rw;
        m_pl += m_count();
        if (rd_fire) m_pr++;
        if (wr_fire) m_pw++;
        if (sv && crdy && pre_busy) m_busy[st] = 1'b0;
        if (sv && crdy && !pre_busy) m_err = 1'b1;
        if (rd_fire) begin
            m_busy[lo] = 1'b1; m_tag[lo] = tg; m_wr[lo] = 1'b1;
        end
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic rd(input logic [7:0] tg);
        drive_cycle(1'b1, 1'b0, tg, 1'b1, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic rsp(input logic [2:0] st);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, st, 1'b1);
    endtask

    always @(negedge clk) begin
        stat_t s;
        req_t  r;
        rsp_t  p;
        #2;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("core_req_ready", core_req_ready, s.ready);
            chk("mem_req_valid", mem_req_valid, s.mval);
            chk("mem_rsp_ready", mem_rsp_ready, s.srdy);
            chk("core_rsp_valid", core_rsp_valid, s.cval);
            chk("pending", pending, s.pend);
            chk("busy", busy, s.pend != 0);
            chk("err_unmatched", err_unmatched, s.err);
            chk("perf_reads", perf_reads, s.pr);
            chk("perf_writes", perf_writes, s.pw);
            chk("perf_latency", perf_latency, s.pl);
        end
        if (mem_req_valid && mem_req_ready) begin
            chk("req_expected", req_q.size() > 0, 1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk("mem_req_rw", mem_req_rw, r.rw);
                chk("mem_req_addr", mem_req_addr, r.addr);
                chk("mem_req_data", mem_req_data, r.data);
                chk("mem_req_byteen", mem_req_byteen, r.be);
                chk("mem_req_tag", mem_req_tag, r.tag);
            end
        end
        if (core_rsp_valid && core_rsp_ready) begin
            chk("rsp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
                p = rsp_q.pop_front();
                chk("core_rsp_data", core_rsp_data, p.data);
                if (p.known) chk("core_rsp_tag", core_rsp_tag, p.tag);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bq[$];
        bit sv;
        logic [2:0] st;

        do_reset();
        // Scenario 1: single read round trip
        rd(8'h5A);
        #1 chk("t1_tag", mem_req_tag, 0);
        idle();
        #1 chk("t1_pend", pending, 1);
        rsp(3'd0);
        #1 chk("t1_rsp_tag", core_rsp_tag, 8'h5A);
        idle();
        #1 chk("t1_pend0", pending, 0);

        // Scenario 2: fill the table; writes still pass
        for (int i = 0; i < 8; i++) begin
            rd(8'(8'h10 + i));
            #1 chk("t2_slot", mem_req_tag, i);
        end
        rd(8'h77);
        #1 chk("t2_full_stall", core_req_ready, 0);
        drive_cycle(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 3'd0, 1'b1);
        #1 chk("t2_wr_ready", core_req_ready, 1);
        chk("t2_wr_tag", mem_req_tag, 0);
        chk("t2_pend", pending, 8);

        // Scenario 3: freed slot not visible to same-cycle alloc
        drive_cycle(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 3'd3, 1'b1);
        #1 chk("t3_stall", core_req_ready, 0);
        chk("t3_rsp_tag", core_rsp_tag, 8'h13);
        rd(8'hAB);
        #1 chk("t3_slot", mem_req_tag, 3);
        idle();
        #1 chk("t3_pend", pending, 8);

        // Scenario 4: response to a free slot
        rsp(3'd2);
        idle();
        #1 chk("t4_pend7", pending, 7);
        rsp(3'd2);
        #1 chk("t4_fwd", core_rsp_valid, 1);
        idle();
        #1 chk("t4_err", err_unmatched, 1);
        chk("t4_pend", pending, 7);
        idle();
        #1 chk("t4_sticky", err_unmatched, 1);

        // Scenario 5: reset mid-operation
        do_reset();
        rd(8'h01); rd(8'h02); rd(8'h03);
        do_reset();
        #1 chk("t5_pend", pending, 0);
        chk("t5_busy", busy, 0);
        rd(8'h04);
        #1 chk("t5_slot", mem_req_tag, 0);

        // Scenario 6: perf counters
        do_reset();
        rd(8'hC1); rd(8'hC2);
        drive_cycle(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
        idle();
        rsp(3'd0); rsp(3'd1);
        idle();
`ifdef MEM_TRACKER_PERF_EN
        #1 chk("t6_reads", perf_reads, 2);
        chk("t6_writes", perf_writes, 1);
        chk("t6_latency", perf_latency, 8);
`else
        #1 chk("t6_reads_off", perf_reads, 0);
        chk("t6_latency_off", perf_latency, 0);
`endif

        // Randomized phase
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            bq.delete();
            for (int i = 0; i < 8; i++) if (m_busy[i]) bq.push_back(i);
            sv = 1'b0;
            st = 3'($urandom);
            if (bq.size() > 0 && $urandom_range(0, 2) == 0) begin
                sv = 1'b1;
                st = 3'(bq[$urandom_range(0, bq.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                sv = 1'b1;
            end
            drive_cycle($urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) == 0,
                        8'($urandom),
                        $urandom_range(0, 3) != 0,
                        sv, st,
                        $urandom_range(0, 3) != 0);
        end
        idle();
        core_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        #5;
        chk("req_q_drained", req_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
